// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: shared register offsets, STATUS bit positions, FSM encodings
package uart_tx_mmio_pkg;
    localparam logic [31:0] OFS_TXDATA  = 32'd0;
    localparam logic [31:0] OFS_STATUS  = 32'd4;
    localparam logic [31:0] OFS_DIVISOR = 32'd8;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic busy, input logic ovf,
                                                input logic [7:0] cnt);
        logic [31:0] w;
        w = '0;
        w[ST_FULL] = full;
        w[ST_EMPTY] = empty;
        w[ST_BUSY] = busy;
        w[ST_OVF] = ovf;
        w[ST_COUNT +: 8] = cnt;
        return w;
    endfunction
endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// uart_tx_mmio_fifo: synchronous FIFO with first-word-fall-through output
//   clock, reset       : clock, synchronous active-high reset
//   i_push, i_din      : enqueue request/data (ignored when full)
//   i_pop              : dequeue request (ignored when empty)
//   o_dout             : head entry, valid whenever !o_empty
//   o_full/o_empty     : occupancy flags; o_count 0..DEPTH
module uart_tx_mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_wr, w_rd;
    assign o_full = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_dout = r_mem[r_rd];
    // full/empty are pre-edge values, so a push into a full FIFO drops even with a pop
    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr] <= i_din;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
        end else begin
            r_wr <= w_wr ? r_wr + AW'(1) : r_wr;
            r_rd <= w_rd ? r_rd + AW'(1) : r_rd;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with TX FIFO and programmable baud divisor
//   clock, reset : clock, synchronous active-high reset
//   address      : bus address (TXDATA=BASE, STATUS=BASE+4, DIVISOR=BASE+8)
//   width        : byte-lane enables, unused (full-word decode)
//   write,dataIn : store strobe and data
//   dataOut      : registered load data, 0 for unmatched addresses
//   tx           : serial line, idle high
//   irq          : FIFO empty and transmitter idle
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hf0000010,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DATA_BITS  = 8,
    parameter int          STOP_BITS  = 1,
    parameter int          RESET_DIV  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [3:0]  width,
    input  logic        write,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic w_sel_data, w_sel_status, w_sel_div;
    logic w_full, w_empty, w_push, w_pop, w_tick, w_last_data, w_last_stop;
    logic [AW:0] w_cnt;
    logic [DATA_BITS-1:0] w_fifo_dout;
    logic [31:0] w_status;
    logic w_unused;
    logic [1:0] r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [15:0] r_div, r_bdiv, r_baud;
    logic [3:0] r_bit;
    logic r_ovf, r_tx, r_irq;
    logic [31:0] r_dout;
    assign w_sel_data = address == BASE_ADDR + OFS_TXDATA;
    assign w_sel_status = address == BASE_ADDR + OFS_STATUS;
    assign w_sel_div = address == BASE_ADDR + OFS_DIVISOR;
    assign w_push = write && w_sel_data;
    assign w_tick = r_baud == 16'd0;
    assign w_last_data = r_bit == 4'(DATA_BITS - 1);
    assign w_last_stop = r_bit == 4'(STOP_BITS - 1);
    // pop from IDLE, or at the end of the last stop bit so frames run back-to-back
    assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_tick && w_last_stop));
    assign w_status = status_word(w_full, w_empty, r_state != S_IDLE, r_ovf, 8'(w_cnt));
    assign w_unused = ^{width, dataIn[31:16]};
    assign dataOut = r_dout;
    assign tx = r_tx;
    assign irq = r_irq;
    uart_tx_mmio_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (dataIn[DATA_BITS-1:0]),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= 16'(RESET_DIV);
            r_ovf <= 1'b0;
            r_dout <= '0;
            r_irq <= 1'b1;
        end else begin
            if (write && w_sel_div) r_div <= dataIn[15:0] == 16'd0 ? 16'd1 : dataIn[15:0];
            if (write && w_sel_status) r_ovf <= 1'b0;
            else if (w_push && w_full) r_ovf <= 1'b1;
            r_dout <= w_sel_status ? w_status : w_sel_div ? {16'h0, r_div} : 32'h0;
            r_irq <= w_empty && r_state == S_IDLE;
        end
    end
    // the divisor is copied into r_bdiv at frame start so mid-frame writes only affect the next frame
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx <= 1'b1;
            r_shreg <= '0;
            r_bdiv <= 16'(RESET_DIV);
            r_baud <= '0;
            r_bit <= '0;
        end else if (w_pop) begin
            r_state <= S_START;
            r_tx <= 1'b0;
            r_shreg <= w_fifo_dout;
            r_bdiv <= r_div;
            r_baud <= r_div - 16'd1;
            r_bit <= '0;
        end else if (r_state != S_IDLE) begin
            r_baud <= w_tick ? r_bdiv - 16'd1 : r_baud - 16'd1;
            if (w_tick) begin
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx <= r_shreg[0];
                    end
                    S_DATA: begin
                        r_state <= w_last_data ? S_STOP : S_DATA;
                        r_tx <= w_last_data ? 1'b1 : r_shreg[1];
                        r_shreg <= r_shreg >> 1;
                        r_bit <= w_last_data ? 4'd0 : r_bit + 4'd1;
                    end
                    default: begin
                        r_state <= w_last_stop ? S_IDLE : S_STOP;
                        r_bit <= r_bit + 4'd1;
                    end
                endcase
            end
        end
    end
endmodule
